// File: rtl/seg7_scan_decoder_pkg.sv
// Shared 7-segment definitions: the glyph table used by both the hex encoder
// and this scan decoder, plus a table-driven reverse lookup.
package seg7_pkg;

  // Active-low segment vector, [6]=g .. [0]=a.
  typedef logic [6:0] seg7_t;

  // All segments off (active-low).
  localparam seg7_t SEG7_BLANK = 7'b111_1111;

  // Index is the hex value shown by the glyph.
  localparam seg7_t SEG7_GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // B
    7'b1000110,  // C
    7'b0100001,  // D
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Returns {err, value}. An unknown pattern gives err=1 and value=0.
  function automatic logic [4:0] seg7_decode(input seg7_t s);
    logic [4:0] res;
    res = 5'b1_0000;
    for (int i = 0; i < 16; i++) begin
      if (s == SEG7_GLYPH[i]) res = {1'b0, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_stabilizer.sv
// Front end of the scan decoder: registers the display bus, measures how long
// the registered pattern has been constant and emits a one-cycle fire pulse
// the first time it has been stable for STABLE_CYCLES samples. Also flags the
// first sample of every contiguous run of illegal (multi-digit) enables.
module seg7_stabilizer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  seg7_t                 i_seg_n,
  input  logic [NUM_DIGITS-1:0] i_dig_n,
  output seg7_t                 o_seg_n,
  output logic [NUM_DIGITS-1:0] o_dig_n,
  output logic                  o_fire,
  output logic                  o_illegal_start
);

  localparam int                    CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  seg7_t                 r_seg_n;
  logic [NUM_DIGITS-1:0] r_dig_n;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_fire;
  logic                  r_illegal;
  logic                  r_illegal_start;

  logic                  w_same;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [NUM_DIGITS-1:0] w_zero;
  logic                  w_illegal;

  // Next stability count and illegal-enable detection for the incoming sample.
  always_comb begin
    w_same    = ({i_seg_n, i_dig_n} == {r_seg_n, r_dig_n});
    w_cnt_nxt = '0;
    if (w_same) begin
      w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
    end
    // More than one enable low: clearing the lowest set bit leaves something.
    w_zero    = ~i_dig_n;
    w_illegal = ((w_zero & (w_zero - DIG_ONE)) != '0);
  end

  // Sample the bus, advance the counter, and register the fire / illegal-start pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_n         <= '0;
      r_dig_n         <= '0;
      r_cnt           <= '0;
      r_fire          <= 1'b0;
      r_illegal       <= 1'b0;
      r_illegal_start <= 1'b0;
    end else begin
      r_seg_n         <= i_seg_n;
      r_dig_n         <= i_dig_n;
      r_cnt           <= w_cnt_nxt;
      // Fires only on the transition into saturation, so once per stable pattern.
      r_fire          <= w_same && (r_cnt == (CNT_MAX - CNT_ONE));
      r_illegal       <= w_illegal;
      r_illegal_start <= w_illegal && !r_illegal;
    end
  end

  assign o_seg_n         = r_seg_n;
  assign o_dig_n         = r_dig_n;
  assign o_fire          = r_fire;
  assign o_illegal_start = r_illegal_start;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed active-low 7-segment display bus back into per-digit
// hex values and reports every change of a digit on a valid/ready stream.
// Digit storage, the pending-change bitmap, the event emitter and the
// illegal-enable counter live here; sampling/settling is in seg7_stabilizer.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [6:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         dig_n,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_DIGITS)-1:0] out_digit,
  output logic [3:0]                    out_value,
  output logic                          out_err,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [ERR_W-1:0]              err_count
);

  localparam int                    IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);
  localparam logic [ERR_W-1:0]      ERR_ONE = ERR_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Settled samples from the front end.
  seg7_t                 w_seg_n;
  logic [NUM_DIGITS-1:0] w_dig_n;
  logic                  w_fire;
  logic                  w_illegal_start;

  // Per-digit stored state.
  logic [3:0]            r_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_errd;
  logic [NUM_DIGITS-1:0] r_known;
  logic [NUM_DIGITS-1:0] r_pend;

  // Emitter state and registered outputs.
  logic [0:0]            r_state;
  logic                  r_out_valid;
  logic [IDX_W-1:0]      r_out_digit;
  logic [3:0]            r_out_value;
  logic                  r_out_err;
  logic [ERR_W-1:0]      r_err_count;

  // Decode-side combinational signals.
  logic [4:0]            w_dec;
  logic [NUM_DIGITS-1:0] w_zero;
  logic                  w_onehot;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_load;
  logic [NUM_DIGITS-1:0] w_set;

  // Emitter-side combinational signals.
  logic                  w_any;
  logic [IDX_W-1:0]      w_low;
  logic [NUM_DIGITS-1:0] w_clr;

  seg7_stabilizer #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_seg_n         (seg_n),
    .i_dig_n         (dig_n),
    .o_seg_n         (w_seg_n),
    .o_dig_n         (w_dig_n),
    .o_fire          (w_fire),
    .o_illegal_start (w_illegal_start)
  );

  // Decode the settled pattern and decide whether it changes the addressed digit.
  always_comb begin
    w_dec    = seg7_decode(w_seg_n);
    w_zero   = ~w_dig_n;
    w_onehot = (w_zero != '0) && ((w_zero & (w_zero - DIG_ONE)) == '0);
    w_idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_zero[i]) w_idx = IDX_W'(i);
    end
    // Blank periods, illegal enables and the blank glyph never touch storage.
    w_load = w_fire && w_onehot && (w_seg_n != SEG7_BLANK) &&
             (!r_known[w_idx] || ({r_errd[w_idx], r_val[w_idx]} != w_dec));
    w_set  = w_load ? (DIG_ONE << w_idx) : '0;
  end

  // Pick the lowest-index pending digit for the emitter.
  always_comb begin
    w_any = (r_pend != '0);
    w_low = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_pend[i]) w_low = IDX_W'(i);
    end
    w_clr = ((r_state == ST_IDLE) && w_any) ? (DIG_ONE << w_low) : '0;
  end

  // Per-digit storage and pending bitmap; a new change wins over the emitter's clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_val[i] <= '0;
      r_errd  <= '0;
      r_known <= '0;
      r_pend  <= '0;
    end else begin
      if (w_load) begin
        r_val[w_idx]   <= w_dec[3:0];
        r_errd[w_idx]  <= w_dec[4];
        r_known[w_idx] <= 1'b1;
      end
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  // Emitter FSM: IDLE latches the next pending digit, HOLD waits for the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_digit <= '0;
      r_out_value <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_out_digit <= w_low;
            r_out_value <= r_val[w_low];
            r_out_err   <= r_errd[w_low];
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of illegal-enable runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_illegal_start && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_ONE;
    end
  end

  // Flatten stored digit values onto the digits bus.
  always_comb begin
    digits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[4*i +: 4] = r_val[i];
    end
  end

  assign out_valid = r_out_valid;
  assign out_digit = r_out_digit;
  assign out_value = r_out_value;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus a random
// scan phase, checked every cycle against a behavioural reference model.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 4;
  localparam int EW = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_digit;
  logic [3:0]  out_value;
  logic        out_err;
  logic [15:0] digits;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (S),
    .ERR_W         (EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_n     (seg_n),
    .dig_n     (dig_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_value (out_value),
    .out_err   (out_err),
    .digits    (digits),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] glyph [16];
  localparam logic [6:0] BLANK = 7'b1111111;

  // Reference model state
  int         m_val [ND];
  int         m_err [ND];
  bit         m_known [ND];
  bit         m_pend [ND];
  bit         m_valid;
  int         m_od, m_ov, m_oe;
  int         m_errcnt;
  int         m_run;
  logic [10:0] m_prev;
  bit         m_sched;
  logic [6:0] m_ss;
  logic [3:0] m_sd;
  bit         m_ill_sched;
  bit         m_prev_ill;

  // Observed handshakes
  int hs_dig [$];
  int hs_val [$];
  int hs_err [$];

  function automatic int zeros4(input logic [3:0] d);
    int z = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) z++;
    return z;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model, given the inputs present at that edge.
  task automatic model_edge(input logic [6:0] s, input logic [3:0] d, input bit r, input bit rn);
    int lo;
    int idx;
    int dv, de;
    if (!rn) begin
      for (int i = 0; i < ND; i++) begin
        m_val[i] = 0; m_err[i] = 0; m_known[i] = 0; m_pend[i] = 0;
      end
      m_valid = 0; m_od = 0; m_ov = 0; m_oe = 0; m_errcnt = 0;
      m_prev = '0; m_run = 1; m_sched = 0; m_ill_sched = 0; m_prev_ill = 0;
      return;
    end
    // Emitter acts on the stored values and pending set from before this edge.
    if (!m_valid) begin
      lo = -1;
      for (int i = ND - 1; i >= 0; i--) if (m_pend[i]) lo = i;
      if (lo >= 0) begin
        m_od = lo; m_ov = m_val[lo]; m_oe = m_err[lo];
        m_pend[lo] = 0;
        m_valid = 1;
      end
    end else if (r) begin
      m_valid = 0;
    end
    // A decode scheduled by a pattern that became stable at the previous edge.
    if (m_sched && zeros4(m_sd) == 1 && m_ss != BLANK) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (!m_sd[i]) idx = i;
      dv = 0; de = 1;
      for (int g = 0; g < 16; g++) if (glyph[g] == m_ss) begin dv = g; de = 0; end
      if (!m_known[idx] || m_val[idx] != dv || m_err[idx] != de) begin
        m_val[idx] = dv; m_err[idx] = de; m_known[idx] = 1; m_pend[idx] = 1;
      end
    end
    if (m_ill_sched && m_errcnt < ERR_MAX) m_errcnt++;
    // Track how long the current input has been held.
    if ({s, d} == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = {s, d};
    m_sched = (m_run == S);
    m_ss = s; m_sd = d;
    m_ill_sched = (zeros4(d) >= 2) && !m_prev_ill;
    m_prev_ill = (zeros4(d) >= 2);
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] d, input bit r, input bit rn);
    logic [15:0] exp_digits;
    seg_n = s; dig_n = d; out_ready = r; rst_n = rn;
    if (rn && r && out_valid === 1'b1) begin
      hs_dig.push_back(int'(out_digit));
      hs_val.push_back(int'(out_value));
      hs_err.push_back(int'(out_err));
    end
    @(posedge clk);
    model_edge(s, d, r, rn);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_digit", 32'(out_digit), 32'(m_od));
      chk("out_value", 32'(out_value), 32'(m_ov));
      chk("out_err",   32'(out_err),   32'(m_oe));
    end
    exp_digits = '0;
    for (int i = 0; i < ND; i++) exp_digits[4*i +: 4] = 4'(m_val[i]);
    chk("digits", 32'(digits), 32'(exp_digits));
    chk("err_count", 32'(err_count), 32'(m_errcnt));
  endtask

  task automatic clear_hs();
    hs_dig.delete(); hs_val.delete(); hs_err.delete();
  endtask

  initial begin
    int          v3 [4];
    logic [3:0]  dd;
    logic [3:0]  ill_tab [7];
    int          kind, hold, dsel;
    logic [6:0]  rs;
    logic [3:0]  rd;

    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    v3 = '{1, 10, 15, 8};
    ill_tab = '{4'b1100, 4'b0101, 4'b1001, 4'b0011, 4'b0110, 4'b1010, 4'b0001};

    // Reset state
    step(BLANK, 4'b1111, 1'b1, 1'b0);
    step(BLANK, 4'b1111, 1'b1, 1'b0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);

    // 1: value 2 on digit 0 for 10 cycles
    clear_hs();
    repeat (10) step(7'b0100100, 4'b1110, 1'b1, 1'b1);
    repeat (3) step(BLANK, 4'b1111, 1'b1, 1'b1);
    chk("t1_events", 32'(hs_dig.size()), 32'd1);
    if (hs_dig.size() > 0) begin
      chk("t1_digit", 32'(hs_dig[0]), 32'd0);
      chk("t1_value", 32'(hs_val[0]), 32'd2);
      chk("t1_err",   32'(hs_err[0]), 32'd0);
    end
    chk("t1_digits", 32'(digits[3:0]), 32'd2);

    // 2: pattern held one cycle short of stable
    clear_hs();
    repeat (S - 1) step(glyph[5], 4'b1101, 1'b1, 1'b1);
    repeat (4) step(BLANK, 4'b1101, 1'b1, 1'b1);
    repeat (2) step(BLANK, 4'b1111, 1'b1, 1'b1);
    chk("t2_events", 32'(hs_dig.size()), 32'd0);
    chk("t2_digits", 32'(digits), 32'h0002);

    // 3: scan four digits with ready low, then drain
    clear_hs();
    for (int k = 0; k < 4; k++) begin
      dd = ~(4'b0001 << k);
      repeat (6) step(glyph[v3[k]], dd, 1'b0, 1'b1);
    end
    chk("t3_hold_valid", 32'(out_valid), 32'd1);
    chk("t3_hold_digit", 32'(out_digit), 32'd0);
    repeat (12) step(BLANK, 4'b1111, 1'b1, 1'b1);
    chk("t3_events", 32'(hs_dig.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (hs_dig.size() > k) begin
        chk("t3_digit", 32'(hs_dig[k]), 32'(k));
        chk("t3_value", 32'(hs_val[k]), 32'(v3[k]));
      end
    end
    chk("t3_digits", 32'(digits), 32'h8FA1);

    // 4: two illegal runs, then an unknown glyph on digit 2
    clear_hs();
    repeat (5) step(glyph[3], 4'b1100, 1'b1, 1'b1);
    repeat (3) step(BLANK, 4'b1111, 1'b1, 1'b1);
    repeat (5) step(glyph[3], 4'b1100, 1'b1, 1'b1);
    repeat (3) step(BLANK, 4'b1111, 1'b1, 1'b1);
    chk("t4_errcnt", 32'(err_count), 32'd2);
    chk("t4_no_events", 32'(hs_dig.size()), 32'd0);
    repeat (6) step(7'b1010101, 4'b1011, 1'b1, 1'b1);
    repeat (4) step(BLANK, 4'b1111, 1'b1, 1'b1);
    chk("t4_events", 32'(hs_dig.size()), 32'd1);
    if (hs_dig.size() > 0) begin
      chk("t4_digit", 32'(hs_dig[0]), 32'd2);
      chk("t4_value", 32'(hs_val[0]), 32'd0);
      chk("t4_err",   32'(hs_err[0]), 32'd1);
    end

    // 5: counter saturation, then a repeated legal pattern
    repeat (300) begin
      step(glyph[1], 4'b0101, 1'b1, 1'b1);
      step(BLANK, 4'b1111, 1'b1, 1'b1);
    end
    chk("t5_errcnt_sat", 32'(err_count), 32'd255);
    clear_hs();
    repeat (6) step(glyph[7], 4'b0111, 1'b1, 1'b1);
    repeat (3) step(BLANK, 4'b1111, 1'b1, 1'b1);
    repeat (6) step(glyph[7], 4'b0111, 1'b1, 1'b1);
    repeat (4) step(BLANK, 4'b1111, 1'b1, 1'b1);
    chk("t5_events", 32'(hs_dig.size()), 32'd1);
    if (hs_dig.size() > 0) begin
      chk("t5_digit", 32'(hs_dig[0]), 32'd3);
      chk("t5_value", 32'(hs_val[0]), 32'd7);
    end

    // 6: reset while holding an event
    repeat (7) step(glyph[9], 4'b1110, 1'b0, 1'b1);
    chk("t6_hold", 32'(out_valid), 32'd1);
    step(glyph[9], 4'b1110, 1'b0, 1'b0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_digits", 32'(digits), 32'd0);
    clear_hs();
    repeat (8) step(glyph[9], 4'b1110, 1'b1, 1'b1);
    chk("t6_events", 32'(hs_dig.size()), 32'd1);
    if (hs_dig.size() > 0) chk("t6_value", 32'(hs_val[0]), 32'd9);

    // Random scanning with random back-pressure
    repeat (80) begin
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 7));
      dsel = int'($urandom_range(0, 3));
      rd = ~(4'b0001 << dsel);
      rs = glyph[$urandom_range(0, 15)];
      if (kind == 0) rd = ill_tab[$urandom_range(0, 6)];
      else if (kind == 1) rd = 4'b1111;
      else if (kind == 2) rs = BLANK;
      else if (kind == 3) rs = 7'($urandom);
      repeat (hold) step(rs, rd, bit'($urandom_range(0, 2) != 0), 1'b1);
    end
    repeat (16) step(BLANK, 4'b1111, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
